// File: rtl/mem_port_arbiter_if.sv
// Request/response and memory-side signals of the unified memory port arbiter.
// The arbiter uses the slave modport; the requesters and the memory block use the master modport.
interface mem_port_arbiter_if #(
    parameter int AWIDTH = 32,
    parameter int DWIDTH = 32
);
    logic              if_req_i;
    logic [AWIDTH-1:0] if_addr_i;
    logic              if_gnt_o;
    logic              if_rvalid_o;
    logic [DWIDTH-1:0] if_rdata_o;

    logic              ls_req_i;
    logic              ls_we_i;
    logic [AWIDTH-1:0] ls_addr_i;
    logic [DWIDTH-1:0] ls_wdata_i;
    logic [6:0]        ls_opcode_i;
    logic [2:0]        ls_funct3_i;
    logic              ls_gnt_o;
    logic              ls_rvalid_o;
    logic [DWIDTH-1:0] ls_rdata_o;
    logic              ls_err_o;

    logic [AWIDTH-1:0] mem_addr_o;
    logic [DWIDTH-1:0] mem_data_o;
    logic              mem_read_en_o;
    logic              mem_write_en_o;
    logic [6:0]        mem_opcode_o;
    logic [2:0]        mem_funct3_o;
    logic [DWIDTH-1:0] mem_rdata_i;

    modport slave (
        input  if_req_i, if_addr_i,
        output if_gnt_o, if_rvalid_o, if_rdata_o,
        input  ls_req_i, ls_we_i, ls_addr_i, ls_wdata_i, ls_opcode_i, ls_funct3_i,
        output ls_gnt_o, ls_rvalid_o, ls_rdata_o, ls_err_o,
        output mem_addr_o, mem_data_o, mem_read_en_o, mem_write_en_o, mem_opcode_o, mem_funct3_o,
        input  mem_rdata_i
    );

    modport master (
        output if_req_i, if_addr_i,
        input  if_gnt_o, if_rvalid_o, if_rdata_o,
        output ls_req_i, ls_we_i, ls_addr_i, ls_wdata_i, ls_opcode_i, ls_funct3_i,
        input  ls_gnt_o, ls_rvalid_o, ls_rdata_o, ls_err_o,
        input  mem_addr_o, mem_data_o, mem_read_en_o, mem_write_en_o, mem_opcode_o, mem_funct3_o,
        output mem_rdata_i
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates IF and LS onto one memory port: LS priority with IF starvation guard, misaligned LS trapped.
// Latency: grant cycle N, memory access N+1, response pulse N+2; a grant is only given in IDLE or RESP.
module mem_port_arbiter #(
    parameter int AWIDTH       = 32,
    parameter int DWIDTH       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                rst,
    mem_port_arbiter_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    localparam logic [3:0] LIMIT     = 4'(STARVE_LIMIT);
    localparam logic [6:0] IF_OPCODE = 7'd0;
    localparam logic [2:0] IF_FUNCT3 = 3'b010;

    state_t            r_state;
    logic [3:0]        r_starve;
    logic              r_owner_ls;
    logic              r_we;
    logic [AWIDTH-1:0] r_addr;
    logic [DWIDTH-1:0] r_wdata;
    logic [6:0]        r_opcode;
    logic [2:0]        r_funct3;
    logic              r_if_rvalid;
    logic [DWIDTH-1:0] r_if_rdata;
    logic              r_ls_rvalid;
    logic [DWIDTH-1:0] r_ls_rdata;
    logic              r_ls_err;

    logic w_can_grant;
    logic w_if_first;
    logic w_ls_gnt;
    logic w_if_gnt;
    logic w_ls_mis;
    logic w_access;

    // Grants are gated by rst so every output is low while reset is held.
    assign w_can_grant = rst && (r_state != ACCESS);
    assign w_if_first  = bus.if_req_i && (r_starve == LIMIT);
    assign w_ls_gnt    = w_can_grant && bus.ls_req_i && !w_if_first;
    assign w_if_gnt    = w_can_grant && bus.if_req_i && !w_ls_gnt;
    assign w_access    = (r_state == ACCESS);

    assign w_ls_mis = ((bus.ls_funct3_i[1:0] == 2'b01) && bus.ls_addr_i[0]) ||
                      ((bus.ls_funct3_i[1:0] == 2'b10) && (bus.ls_addr_i[1:0] != 2'b00));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_starve    <= '0;
            r_owner_ls  <= 1'b0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_opcode    <= '0;
            r_funct3    <= '0;
            r_if_rvalid <= 1'b0;
            r_if_rdata  <= '0;
            r_ls_rvalid <= 1'b0;
            r_ls_rdata  <= '0;
            r_ls_err    <= 1'b0;
        end else begin
            r_if_rvalid <= 1'b0;
            r_ls_rvalid <= 1'b0;
            r_ls_err    <= 1'b0;

            if (!bus.if_req_i || w_if_gnt) begin
                r_starve <= '0;
            end else if (w_ls_gnt && (r_starve != LIMIT)) begin
                r_starve <= r_starve + 4'd1;
            end

            if (r_state == ACCESS) begin
                r_state <= RESP;
                if (r_owner_ls) begin
                    r_ls_rvalid <= 1'b1;
                    r_ls_rdata  <= r_we ? '0 : bus.mem_rdata_i;
                end else begin
                    r_if_rvalid <= 1'b1;
                    r_if_rdata  <= bus.mem_rdata_i;
                end
            end else if (w_ls_gnt && w_ls_mis) begin
                // Misaligned: skip the memory cycle entirely, mem_* registers stay untouched.
                r_state     <= RESP;
                r_ls_rvalid <= 1'b1;
                r_ls_err    <= 1'b1;
                r_ls_rdata  <= '0;
            end else if (w_ls_gnt) begin
                r_state    <= ACCESS;
                r_owner_ls <= 1'b1;
                r_we       <= bus.ls_we_i;
                r_addr     <= bus.ls_addr_i;
                r_wdata    <= bus.ls_wdata_i;
                r_opcode   <= bus.ls_opcode_i;
                r_funct3   <= bus.ls_funct3_i;
            end else if (w_if_gnt) begin
                r_state    <= ACCESS;
                r_owner_ls <= 1'b0;
                r_we       <= 1'b0;
                r_addr     <= bus.if_addr_i;
                r_opcode   <= IF_OPCODE;
                r_funct3   <= IF_FUNCT3;
            end else begin
                r_state <= IDLE;
            end
        end
    end

    assign bus.if_gnt_o       = w_if_gnt;
    assign bus.ls_gnt_o       = w_ls_gnt;
    assign bus.if_rvalid_o    = r_if_rvalid;
    assign bus.if_rdata_o     = r_if_rdata;
    assign bus.ls_rvalid_o    = r_ls_rvalid;
    assign bus.ls_rdata_o     = r_ls_rdata;
    assign bus.ls_err_o       = r_ls_err;
    assign bus.mem_addr_o     = r_addr;
    assign bus.mem_data_o     = r_wdata;
    assign bus.mem_opcode_o   = r_opcode;
    assign bus.mem_funct3_o   = r_funct3;
    assign bus.mem_read_en_o  = w_access && !r_we;
    assign bus.mem_write_en_o = w_access && r_we;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a small word memory model behind the port.
module tb_mem_port_arbiter;
    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;
    int   wr_cnt = 0;
    int   rd_cnt = 0;
    int   ifrv_cnt = 0;
    int   snap;
    int   snap2;

    mem_port_arbiter_if #(.AWIDTH(32), .DWIDTH(32)) bus ();

    mem_port_arbiter #(.AWIDTH(32), .DWIDTH(32), .STARVE_LIMIT(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [64] = '{0: 32'h0050_0093, default: 32'h0};

    assign bus.mem_rdata_i = mem[bus.mem_addr_o[7:2]];

    always @(posedge clk) begin
        if (bus.mem_write_en_o) begin
            mem[bus.mem_addr_o[7:2]] <= bus.mem_data_o;
            wr_cnt++;
        end
        if (bus.mem_read_en_o) rd_cnt++;
        if (bus.if_rvalid_o) ifrv_cnt++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic ls_drive(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [6:0] op, input logic [2:0] f3);
        bus.ls_req_i    = 1'b1;
        bus.ls_we_i     = we;
        bus.ls_addr_i   = addr;
        bus.ls_wdata_i  = wdata;
        bus.ls_opcode_i = op;
        bus.ls_funct3_i = f3;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

    initial begin
        rst             = 1'b0;
        bus.if_req_i    = 1'b0;
        bus.if_addr_i   = '0;
        bus.ls_req_i    = 1'b0;
        bus.ls_we_i     = 1'b0;
        bus.ls_addr_i   = '0;
        bus.ls_wdata_i  = '0;
        bus.ls_opcode_i = '0;
        bus.ls_funct3_i = '0;

        // Reset state, with a request pending to show grants stay low in reset.
        @(negedge clk);
        bus.ls_req_i = 1'b1;
        #1;
        check("rst_ls_gnt", bus.ls_gnt_o, 0);
        check("rst_if_gnt", bus.if_gnt_o, 0);
        check("rst_ls_rvalid", bus.ls_rvalid_o, 0);
        check("rst_if_rvalid", bus.if_rvalid_o, 0);
        check("rst_mem_rd", bus.mem_read_en_o, 0);
        check("rst_mem_wr", bus.mem_write_en_o, 0);
        check("rst_mem_addr", bus.mem_addr_o, 0);
        bus.ls_req_i = 1'b0;
        step();
        rst = 1'b1;
        step();

        // Single IF fetch.
        bus.if_req_i  = 1'b1;
        bus.if_addr_i = 32'h0100_0000;
        #1;
        check("if_gnt_c0", bus.if_gnt_o, 1);
        check("if_rd_c0", bus.mem_read_en_o, 0);
        step();
        bus.if_req_i = 1'b0;
        #1;
        check("if_rd_c1", bus.mem_read_en_o, 1);
        check("if_addr_c1", bus.mem_addr_o, 32'h0100_0000);
        check("if_f3_c1", bus.mem_funct3_o, 3'b010);
        check("if_op_c1", bus.mem_opcode_o, 0);
        check("if_rv_c1", bus.if_rvalid_o, 0);
        step();
        check("if_rv_c2", bus.if_rvalid_o, 1);
        check("if_rdata_c2", bus.if_rdata_o, 32'h0050_0093);
        check("if_rd_c2", bus.mem_read_en_o, 0);
        step();
        check("if_rv_c3", bus.if_rvalid_o, 0);
        check("if_rdata_hold", bus.if_rdata_o, 32'h0050_0093);

        // Store word then load it back.
        snap = wr_cnt;
        ls_drive(1'b1, 32'h0100_0010, 32'hDEAD_BEEF, 7'h23, 3'b010);
        #1;
        check("st_gnt", bus.ls_gnt_o, 1);
        step();
        bus.ls_req_i = 1'b0;
        #1;
        check("st_wr_en", bus.mem_write_en_o, 1);
        check("st_rd_en", bus.mem_read_en_o, 0);
        check("st_addr", bus.mem_addr_o, 32'h0100_0010);
        check("st_data", bus.mem_data_o, 32'hDEAD_BEEF);
        check("st_op", bus.mem_opcode_o, 7'h23);
        step();
        check("st_rv", bus.ls_rvalid_o, 1);
        check("st_rdata", bus.ls_rdata_o, 0);
        check("st_err", bus.ls_err_o, 0);
        check("st_wr_after", bus.mem_write_en_o, 0);
        step();
        check("st_wr_pulses", wr_cnt - snap, 1);
        ls_drive(1'b0, 32'h0100_0010, 32'h0, 7'h03, 3'b010);
        #1;
        check("ld_gnt", bus.ls_gnt_o, 1);
        step();
        bus.ls_req_i = 1'b0;
        #1;
        check("ld_rd_en", bus.mem_read_en_o, 1);
        step();
        check("ld_rv", bus.ls_rvalid_o, 1);
        check("ld_rdata", bus.ls_rdata_o, 32'hDEAD_BEEF);
        step();

        // Both requesters held: LS x4, IF, LS with a grant every second cycle.
        bus.if_req_i  = 1'b1;
        bus.if_addr_i = 32'h0100_0000;
        ls_drive(1'b0, 32'h0100_0010, 32'h0, 7'h03, 3'b010);
        for (int i = 0; i < 12; i++) begin
            #1;
            check($sformatf("stv_ls_gnt_%0d", i), bus.ls_gnt_o, (i % 2 == 0) && (i != 8));
            check($sformatf("stv_if_gnt_%0d", i), bus.if_gnt_o, i == 8);
            check($sformatf("stv_ls_rv_%0d", i), bus.ls_rvalid_o, (i == 2) || (i == 4) || (i == 6) || (i == 8));
            check($sformatf("stv_if_rv_%0d", i), bus.if_rvalid_o, i == 10);
            step();
        end
        check("stv_ls_rdata", bus.ls_rdata_o, 32'hDEAD_BEEF);
        check("stv_if_rdata", bus.if_rdata_o, 32'h0050_0093);
        bus.if_req_i = 1'b0;
        bus.ls_req_i = 1'b0;
        step();

        // Misaligned word load.
        snap  = rd_cnt;
        snap2 = wr_cnt;
        ls_drive(1'b0, 32'h0100_0002, 32'h0, 7'h03, 3'b010);
        #1;
        check("mis_gnt", bus.ls_gnt_o, 1);
        step();
        bus.ls_req_i = 1'b0;
        #1;
        check("mis_rv", bus.ls_rvalid_o, 1);
        check("mis_err", bus.ls_err_o, 1);
        check("mis_rdata", bus.ls_rdata_o, 0);
        check("mis_rd_en", bus.mem_read_en_o, 0);
        step();
        check("mis_rv_gone", bus.ls_rvalid_o, 0);
        step();
        check("mis_rd_cnt", rd_cnt - snap, 0);
        check("mis_wr_cnt", wr_cnt - snap2, 0);

        // IF pulses for one cycle while LS owns the port.
        snap = ifrv_cnt;
        ls_drive(1'b0, 32'h0100_0010, 32'h0, 7'h03, 3'b010);
        #1;
        check("pls_ls_gnt", bus.ls_gnt_o, 1);
        step();
        bus.ls_req_i  = 1'b0;
        bus.if_req_i  = 1'b1;
        #1;
        check("pls_if_gnt", bus.if_gnt_o, 0);
        step();
        bus.if_req_i = 1'b0;
        #1;
        check("pls_starve_c2", dut.r_starve, 0);
        check("pls_ls_rv", bus.ls_rvalid_o, 1);
        check("pls_if_gnt_c2", bus.if_gnt_o, 0);
        step();
        step();
        check("pls_starve_end", dut.r_starve, 0);
        check("pls_if_rv_cnt", ifrv_cnt - snap, 0);

        // Reset during the ACCESS cycle of a store.
        snap = wr_cnt;
        ls_drive(1'b1, 32'h0100_0014, 32'h1234_5678, 7'h23, 3'b010);
        #1;
        check("rsta_gnt", bus.ls_gnt_o, 1);
        step();
        bus.ls_req_i = 1'b0;
        #1;
        check("rsta_wr_en", bus.mem_write_en_o, 1);
        rst = 1'b0;
        #1;
        check("rsta_wr_drop", bus.mem_write_en_o, 0);
        check("rsta_addr_drop", bus.mem_addr_o, 0);
        check("rsta_data_drop", bus.mem_data_o, 0);
        check("rsta_rv", bus.ls_rvalid_o, 0);
        step();
        check("rsta_rv_held", bus.ls_rvalid_o, 0);
        check("rsta_mem_word", mem[5], 0);
        check("rsta_wr_cnt", wr_cnt - snap, 0);
        rst = 1'b1;
        #1;
        check("rsta_state", 64'(dut.r_state), 0);
        check("rsta_starve", dut.r_starve, 0);
        step();
        check("rsta_rv_after", bus.ls_rvalid_o, 0);
        check("rsta_rd_after", bus.mem_read_en_o, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
